// File: rtl/sim_ctrl_pkg.sv
// Shared types and constants for the simulation run controller.
package sim_ctrl_pkg;

  typedef enum logic [1:0] {
    StHold = 2'd0,
    StRun  = 2'd1,
    StPass = 2'd2,
    StFail = 2'd3
  } run_state_e;

  localparam logic [1:0] FAIL_NONE     = 2'd0;
  localparam logic [1:0] FAIL_TIMEOUT  = 2'd1;
  localparam logic [1:0] FAIL_EXTERNAL = 2'd2;

endpackage

// File: rtl/run_cycle_counter.sv
// Saturating cycle counter: counts enabled edges and sticks at all-ones.
module run_cycle_counter #(
  parameter int unsigned CNT_W = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             enable,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (enable && (count_q != '1)) begin
      count_d = count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/sim_run_ctrl.sv
// Simulation run controller: holds the DUT in reset, then watches for pass, fail or timeout.
module sim_run_ctrl
  import sim_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W       = 64,
  parameter int unsigned HOLD_CYCLES = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [CNT_W-1:0] max_cycles,
  input  logic [CNT_W-1:0] dump_start,
  input  logic             success,
  input  logic             failure,
  output logic             dut_reset,
  output logic             dump_on,
  output logic             done,
  output logic             pass,
  output logic [1:0]       fail_code,
  output logic [CNT_W-1:0] cycle_count
);

  run_state_e state_q, state_d;
  logic [7:0] hold_cnt_q, hold_cnt_d;
  logic       dump_on_q, dump_on_d;
  logic [1:0] fail_code_q, fail_code_d;
  logic       count_en;
  logic       timeout;

  assign count_en = (state_q == StHold) || (state_q == StRun);

  run_cycle_counter #(
    .CNT_W(CNT_W)
  ) u_counter (
    .clock  (clock),
    .reset  (reset),
    .enable (count_en),
    .count  (cycle_count)
  );

  assign timeout = (max_cycles != '0) && (cycle_count >= max_cycles);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StHold;
      hold_cnt_q  <= '0;
      dump_on_q   <= 1'b0;
      fail_code_q <= FAIL_NONE;
    end else begin
      state_q     <= state_d;
      hold_cnt_q  <= hold_cnt_d;
      dump_on_q   <= dump_on_d;
      fail_code_q <= fail_code_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    hold_cnt_d  = hold_cnt_q;
    fail_code_d = fail_code_q;
    unique case (state_q)
      StHold: begin
        if (hold_cnt_q == 8'(HOLD_CYCLES - 1)) begin
          state_d = StRun;
        end else begin
          hold_cnt_d = hold_cnt_q + 8'd1;
        end
      end
      StRun: begin
        // External failure outranks timeout, which outranks success.
        if (failure) begin
          state_d     = StFail;
          fail_code_d = FAIL_EXTERNAL;
        end else if (timeout) begin
          state_d     = StFail;
          fail_code_d = FAIL_TIMEOUT;
        end else if (success) begin
          state_d = StPass;
        end
      end
      StPass, StFail: begin
      end
      default: begin
      end
    endcase

    dump_on_d = dump_on_q | (count_en && (cycle_count == dump_start));
    if ((state_d == StPass) || (state_d == StFail)) begin
      dump_on_d = 1'b0;
    end
  end

  always_comb begin
    dut_reset = (state_q == StHold);
    done      = (state_q == StPass) || (state_q == StFail);
    pass      = (state_q == StPass);
    fail_code = fail_code_q;
    dump_on   = dump_on_q;
  end

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Self-checking bench for sim_run_ctrl against an analytic model of the run outcome.
module tb_sim_run_ctrl;

  localparam int W    = 8;
  localparam int HOLD = 8;
  localparam int SAT  = 255;
  localparam int MAXC = 320;

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic [W-1:0] max_cycles = '0;
  logic [W-1:0] dump_start = '0;
  logic         success = 1'b0;
  logic         failure = 1'b0;
  logic         dut_reset, dump_on, done, pass;
  logic [1:0]   fail_code;
  logic [W-1:0] cycle_count;

  sim_run_ctrl #(
    .CNT_W      (W),
    .HOLD_CYCLES(HOLD)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .max_cycles (max_cycles),
    .dump_start (dump_start),
    .success    (success),
    .failure    (failure),
    .dut_reset  (dut_reset),
    .dump_on    (dump_on),
    .done       (done),
    .pass       (pass),
    .fail_code  (fail_code),
    .cycle_count(cycle_count)
  );

  always #5 clock = ~clock;

  int n_cmp  = 0;
  int n_fail = 0;

  // Scenario: inputs are functions of the number of edges since release.
  int sc_max, sc_dstart, sc_s_from, sc_s_to, sc_f_from, sc_f_to;

  int   o_cnt  [0:MAXC];
  logic o_rst  [0:MAXC];
  logic o_dump [0:MAXC];
  logic o_done [0:MAXC];
  logic o_pass [0:MAXC];
  logic [1:0] o_code [0:MAXC];

  string fname [6] = '{"cycle_count", "dut_reset", "dump_on", "done", "pass", "fail_code"};

  task automatic sample(input int i);
    o_cnt[i]  = int'(cycle_count);
    o_rst[i]  = dut_reset;
    o_dump[i] = dump_on;
    o_done[i] = done;
    o_pass[i] = pass;
    o_code[i] = fail_code;
  endtask

  function automatic int obs(input int f, input int i);
    case (f)
      0:       return o_cnt[i];
      1:       return int'(o_rst[i]);
      2:       return int'(o_dump[i]);
      3:       return int'(o_done[i]);
      4:       return int'(o_pass[i]);
      5:       return int'(o_code[i]);
      default: return -1;
    endcase
  endfunction

  task automatic run_scenario(input int n);
    max_cycles = W'(sc_max);
    dump_start = W'(sc_dstart);
    success    = 1'b0;
    failure    = 1'b0;
    reset      = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    #1;
    sample(0);
    for (int k = 0; k < n; k++) begin
      success = (k >= sc_s_from) && (k <= sc_s_to);
      failure = (k >= sc_f_from) && (k <= sc_f_to);
      @(posedge clock);
      @(negedge clock);
      sample(k + 1);
    end
    success = 1'b0;
    failure = 1'b0;
  endtask

  // Edge c (0-based) sees inputs for step c; only edges with c >= HOLD are in RUN.
  // reason: 0 pass, 1 timeout, 2 external failure. Returns -1 if the run never ends.
  function automatic int model_term(output int reason);
    reason = 0;
    for (int c = HOLD; c < MAXC; c++) begin
      int cc;
      cc = (c > SAT) ? SAT : c;
      if (c >= sc_f_from && c <= sc_f_to) begin
        reason = 2;
        return c;
      end
      if (sc_max != 0 && cc >= sc_max) begin
        reason = 1;
        return c;
      end
      if (c >= sc_s_from && c <= sc_s_to) begin
        reason = 0;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic test_reset;
    int got [6];
    int exp [6];
    reset = 1'b0;
    #2;
    got = '{int'(cycle_count), int'(dut_reset), int'(dump_on), int'(done), int'(pass),
            int'(fail_code)};
    exp = '{0, 1, 0, 0, 0, 0};
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (got[f] !== exp[f]) begin
        n_fail++;
        $display("FAIL reset_%s: got %0d expected %0d", fname[f], got[f], exp[f]);
      end
    end
    repeat (3) @(posedge clock);
    #1;
    n_cmp++;
    if (cycle_count !== '0 || dut_reset !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_held: got count %0d dut_reset %0b expected 0 1",
               cycle_count, dut_reset);
    end
  endtask

  task automatic test_pass;
    int ti [11] = '{7, 8, 12, 13, 20, 21, 21, 21, 21, 29, 29};
    int tf [11] = '{1, 1, 2, 2, 3, 3, 4, 0, 2, 0, 5};
    int te [11] = '{1, 0, 0, 1, 0, 1, 1, 21, 0, 21, 0};
    sc_max = 0; sc_dstart = 12; sc_s_from = 20; sc_s_to = 20; sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(30);
    for (int j = 0; j < 11; j++) begin
      n_cmp++;
      if (obs(tf[j], ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL pass_%s@%0d: got %0d expected %0d", fname[tf[j]], ti[j],
                 obs(tf[j], ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_timeout;
    int ti [6] = '{50, 51, 51, 51, 51, 59};
    int tf [6] = '{3, 3, 4, 5, 0, 0};
    int te [6] = '{0, 1, 0, 1, 51, 51};
    sc_max = 50; sc_dstart = 200; sc_s_from = 1000; sc_s_to = 1000;
    sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(60);
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (obs(tf[j], ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL timeout_%s@%0d: got %0d expected %0d", fname[tf[j]], ti[j],
                 obs(tf[j], ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_simultaneous;
    int ti [5] = '{30, 31, 31, 31, 31};
    int tf [5] = '{3, 3, 5, 4, 0};
    int te [5] = '{0, 1, 2, 0, 31};
    sc_max = 30; sc_dstart = 200; sc_s_from = 30; sc_s_to = 200; sc_f_from = 30; sc_f_to = 200;
    run_scenario(40);
    for (int j = 0; j < 5; j++) begin
      n_cmp++;
      if (obs(tf[j], ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL simul_%s@%0d: got %0d expected %0d", fname[tf[j]], ti[j],
                 obs(tf[j], ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_success_in_hold;
    int ti [6] = '{8, 30, 60, 61, 61, 61};
    int tf [6] = '{3, 3, 3, 3, 5, 4};
    int te [6] = '{0, 0, 0, 1, 1, 0};
    sc_max = 60; sc_dstart = 200; sc_s_from = 0; sc_s_to = 7; sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(70);
    for (int j = 0; j < 6; j++) begin
      n_cmp++;
      if (obs(tf[j], ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL hold_success_%s@%0d: got %0d expected %0d", fname[tf[j]], ti[j],
                 obs(tf[j], ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_dump_zero;
    int ti [3] = '{0, 1, 5};
    int te [3] = '{0, 1, 1};
    sc_max = 0; sc_dstart = 0; sc_s_from = 1000; sc_s_to = 1000; sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(5);
    for (int j = 0; j < 3; j++) begin
      n_cmp++;
      if (obs(2, ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL dump_zero@%0d: got %0d expected %0d", ti[j], obs(2, ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_saturation;
    int ti [4] = '{255, 300, 300, 300};
    int tf [4] = '{0, 0, 3, 2};
    int te [4] = '{255, 255, 0, 1};
    sc_max = 0; sc_dstart = 250; sc_s_from = 1000; sc_s_to = 1000;
    sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(300);
    for (int j = 0; j < 4; j++) begin
      n_cmp++;
      if (obs(tf[j], ti[j]) !== te[j]) begin
        n_fail++;
        $display("FAIL sat_%s@%0d: got %0d expected %0d", fname[tf[j]], ti[j],
                 obs(tf[j], ti[j]), te[j]);
      end
    end
  endtask

  task automatic test_mid_run_reset;
    int got [6];
    int exp [6];
    sc_max = 0; sc_dstart = 5; sc_s_from = 1000; sc_s_to = 1000; sc_f_from = 1000; sc_f_to = 1000;
    run_scenario(40);
    n_cmp++;
    if (o_dump[40] !== 1'b1 || o_rst[40] !== 1'b0 || o_cnt[40] !== 40) begin
      n_fail++;
      $display("FAIL midrst_pre: got dump %0b dut_reset %0b count %0d expected 1 0 40",
               o_dump[40], o_rst[40], o_cnt[40]);
    end
    #2;
    reset = 1'b0;
    #1;
    got = '{int'(cycle_count), int'(dut_reset), int'(dump_on), int'(done), int'(pass),
            int'(fail_code)};
    exp = '{0, 1, 0, 0, 0, 0};
    for (int f = 0; f < 6; f++) begin
      n_cmp++;
      if (got[f] !== exp[f]) begin
        n_fail++;
        $display("FAIL midrst_%s: got %0d expected %0d", fname[f], got[f], exp[f]);
      end
    end
    @(negedge clock);
    reset = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clock);
      @(negedge clock);
      n_cmp++;
      if (dut_reset !== (k < HOLD) || int'(cycle_count) !== k) begin
        n_fail++;
        $display("FAIL midrst_hold@%0d: got dut_reset %0b count %0d expected %0b %0d",
                 k, dut_reset, cycle_count, (k < HOLD), k);
      end
    end
  endtask

  task automatic test_random;
    int t, reason, n;
    int e [6];
    n = 120;
    for (int it = 0; it < 12; it++) begin
      sc_max    = ($urandom_range(0, 3) == 0) ? 0 : int'($urandom_range(5, 110));
      sc_dstart = $urandom_range(0, 130);
      sc_s_from = $urandom_range(0, 115);
      sc_s_to   = sc_s_from + int'($urandom_range(0, 4));
      if ($urandom_range(0, 2) == 0) begin
        sc_f_from = $urandom_range(0, 115);
        sc_f_to   = sc_f_from + int'($urandom_range(0, 4));
      end else begin
        sc_f_from = 1000;
        sc_f_to   = 1000;
      end
      run_scenario(n);
      t = model_term(reason);
      for (int k = 0; k <= n; k++) begin
        bit term;
        term = (t >= 0) && (k > t);
        e[0] = term ? ((t + 1 > SAT) ? SAT : t + 1) : ((k > SAT) ? SAT : k);
        e[1] = (k < HOLD) ? 1 : 0;
        e[2] = (!term && k > sc_dstart) ? 1 : 0;
        e[3] = term ? 1 : 0;
        e[4] = (term && reason == 0) ? 1 : 0;
        e[5] = term ? reason : 0;
        for (int f = 0; f < 6; f++) begin
          n_cmp++;
          if (obs(f, k) !== e[f]) begin
            n_fail++;
            $display("FAIL rand%0d_%s@%0d: got %0d expected %0d", it, fname[f], k,
                     obs(f, k), e[f]);
          end
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_pass();
    test_timeout();
    test_simultaneous();
    test_success_in_hold();
    test_dump_zero();
    test_saturation();
    test_mid_run_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
